deadlock_stall_detector: RTL

Per-kernel deadlock detector in the co-simulation deadlock-monitor path. It consumes the per-channel AXI-Stream blocked flags and the per-instance idle and blocked flags that the kernel monitor top gathers. It qualifies them over a programmable persistence window and drives the single `block` flag that the top reports as "find kernel block." It also latches a snapshot of which channels were stalled and keeps a saturating count of stalled cycles for the end-of-run report.

---
 rtl/deadlock_mon_pkg.sv | 14 +
 rtl/deadlock_sat_counter.sv | 19 +
 rtl/deadlock_stall_detector.sv | 104 ++++++++++
 3 files changed

// File: rtl/deadlock_mon_pkg.sv
// Shared deadlock-monitor types and defaults.
// The kernel monitor top and every per-kernel detector import this package.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } det_state_e;

  localparam int DEF_THRESHOLD = 1024;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/deadlock_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Clear takes priority over increment, and the count holds at all-ones.
module deadlock_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/deadlock_stall_detector.sv
// Per-kernel deadlock detector: qualifies the kernel stall condition over a persistence
// window, latches the stalled-channel snapshot and counts stalled cycles.
module deadlock_stall_detector
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS    = 4,
  parameter int N_INST    = 1,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_AXIS-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              block_pulse,
  output logic [N_AXIS-1:0] block_chan_mask,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int            PW  = $clog2(THRESHOLD + 1);
  localparam logic [PW-1:0] THR = PW'(THRESHOLD);

  logic [N_AXIS-1:0] chan_stall, active, stalled_active;
  logic              stall;

  assign active         = ~inst_idle_sigs;
  assign chan_stall     = axis_block_sigs & ~inst_idle_sigs;
  assign stalled_active = chan_stall & active;
  // An all-idle kernel is never stalled unless an instance self-reports.
  assign stall = (|inst_block_sigs) | ((|active) & (stalled_active == active));

  det_state_e        state, state_n;
  logic [PW-1:0]     persist, persist_n, persist_inc;
  logic              block_n, pulse_n;
  logic [N_AXIS-1:0] mask_n;

  // IDLE always holds persist at zero, so IDLE and SUSPECT share the step logic;
  // this also lets THRESHOLD=1 jump straight from IDLE to BLOCKED.
  assign persist_inc = persist + PW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      persist         <= '0;
      block           <= 1'b0;
      block_pulse     <= 1'b0;
      block_chan_mask <= '0;
    end else begin
      state           <= state_n;
      persist         <= persist_n;
      block           <= block_n;
      block_pulse     <= pulse_n;
      block_chan_mask <= mask_n;
    end
  end

  always_comb begin
    state_n   = state;
    persist_n = persist;
    pulse_n   = 1'b0;
    mask_n    = block_chan_mask;
    if (clear) begin
      state_n   = IDLE;
      persist_n = '0;
      mask_n    = '0;
    end else begin
      case (state)
        IDLE, SUSPECT: begin
          if (stall) begin
            persist_n = persist_inc;
            if (persist_inc == THR) begin
              state_n = BLOCKED;
              pulse_n = 1'b1;
              mask_n  = stalled_active;
            end else begin
              state_n = SUSPECT;
            end
          end else begin
            state_n   = IDLE;
            persist_n = '0;
          end
        end
        BLOCKED: state_n = BLOCKED;
        default: begin
          state_n   = IDLE;
          persist_n = '0;
        end
      endcase
    end
    block_n = (state_n == BLOCKED);
  end

  deadlock_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (stall),
    .cnt   (stall_cycles)
  );

endmodule
